rgb_led_sequencer: RTL and testbench
====================================

// Module: rgb_led_sequencer
// PURPOSE
//   Controller for the board RGB(+W) LED. Debounces raw sw and btn[3:0] and sets
//   the LED colour in one of two modes:
//   - Manual: buttons toggle colour channels and step the brightness.
//   - Auto: a timed colour sequence that the user can pause and resume.
//   A PWM dimmer drives all four LED outputs. Sits between board I/O pins and LED pins.
// PARAMETERS
//   DEB_CYCLES   250000    consecutive stable cycles before a debounced input changes
//   STEP_CYCLES  25000000  cycles per colour step in auto mode (>=2)
//   PWM_BITS     4         width of PWM counter and brightness register
// PORTS
//   clk     in   1  system clock, all logic rising-edge
//   rst_n   in   1  asynchronous active-low reset
//   sw      in   1  raw mode switch: 0 = manual, 1 = auto
//   btn     in   4  raw buttons, active-high, asynchronous to clk
//   led_r   out  1  red LED drive (registered)
//   led_b   out  1  blue LED drive (registered)
//   led_g   out  1  green LED drive (registered)
//   led_w   out  1  white LED drive (registered)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - All LED outputs 0.
//   - Debounced sw/btn 0; manual enables {b,g,r}=0; bright = 2^PWM_BITS-1.
//   - step=0, step timer=0, pwm_cnt=0, state=MANUAL.
//   - Release is synchronous to the next clk edge.
// - Input conditioning, per bit of sw and btn:
//   - 2-FF synchronizer feeds a debounce counter.
//   - The debounced value takes the synced value after DEB_CYCLES consecutive
//     cycles of disagreement; any agreement clears the counter.
//   - press[i] is a 1-cycle pulse on the rising edge of debounced btn[i].
// - FSM states: MANUAL, AUTO, PAUSE.
//   - MANUAL -> AUTO when debounced sw=1; this clears step and the step timer.
//   - AUTO <-> PAUSE on press[3].
//   - AUTO/PAUSE -> MANUAL when debounced sw=0.
//   - Manual enables and bright are retained across mode changes.
// - MANUAL mode:
//   - press[0]/[1]/[2] toggle r/g/b enable.
//   - press[3] increments bright, wrapping max -> 0.
//   - colour = {b,g,r} enables.
// - AUTO mode:
//   - The timer counts 0..STEP_CYCLES-1; at the terminal count step += 1
//     (3 bits, 7 -> 0) and the timer returns to 0.
//   - colour = step (bit0=r, bit1=g, bit2=b).
// - PAUSE mode: timer and step hold; colour = step.
// - PWM:
//   - pwm_cnt is free-running, PWM_BITS wide, wraps.
//   - pwm_on = (pwm_cnt <= bright), so duty = (bright+1)/2^PWM_BITS; bright=max is always on.
// - Outputs, registered (1 cycle after colour/pwm_on):
//   - led_r/g/b = colour bit & pwm_on.
//   - led_w = (colour == 3'b111) & pwm_on.
// - Simultaneous events:
//   - Several presses in one cycle all take effect.
//   - A debounced sw edge in the same cycle as a press: the mode change wins and
//     the press is discarded.
// - Mid-operation reset clears everything immediately, with no output glitch beyond
//   the async clear.
// TESTING (DEB_CYCLES=4, STEP_CYCLES=8, PWM_BITS=2)
// 1. Apply reset with btn=4'hF held, release reset, drop btn
//    -> all LEDs 0 throughout; no toggles once btns stay low.
// 2. btn[0] high for 3 cycles, then low -> no change.
//    btn[0] held 10 cycles -> led_r=1 continuously (bright=3, 100% duty),
//    other LEDs 0.
// 3. Enable r,g,b via btn[0..2] -> led_w=1. Press btn[3] once -> bright 3->0:
//    led_r/g/b/w each high exactly 1 cycle in every 4.
// 4. sw=1, stable -> LEDs follow step 0,1,2..7,0:
//    - step 1 = r only, step 3 = r+g, step 7 = r+g+b+w;
//    - each step lasts 8 cycles.
// 5. In auto at step 2, press btn[3] -> step frozen for 40 cycles;
//    press again -> sequencing resumes from step 2.
//    sw=0 -> manual enables from test 3 restored.
// 6. Pull rst_n low mid-step in auto -> LEDs 0 within the same cycle;
//    after release the state is MANUAL with enables cleared.

Source files
------------

// File: rtl/rgb_led_sequencer.sv
// RGB(+W) LED controller: debounced switch/buttons, manual or timed
// auto colour sequence, PWM dimming of all four LED drives.
module rgb_led_sequencer #(
  parameter int DEB_CYCLES  = 250000,
  parameter int STEP_CYCLES = 25000000,
  parameter int PWM_BITS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  input  logic [3:0] btn,
  output logic       led_r,
  output logic       led_b,
  output logic       led_g,
  output logic       led_w
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]          raw;
  logic [4:0]          sync1;
  logic [4:0]          sync2;
  logic [4:0]          deb;
  logic [4:0]          deb_q;
  logic [DW-1:0]       cnt [5];
  logic [3:0]          press;
  logic                deb_sw;

  logic [2:0]          en;
  logic [PWM_BITS-1:0] bright;
  logic [2:0]          step;
  logic [TW-1:0]       timer;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic                clr_step;
  logic [2:0]          en_flip;
  logic                bump;
  logic [2:0]          colour;
  logic                pwm_on;

  assign raw    = {sw, btn};
  assign press  = deb[3:0] & ~deb_q[3:0];
  assign deb_sw = deb[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // any cycle of agreement restarts the stability count
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MANUAL;
    else        state <= state_nxt;
  end

  // a mode change swallows any press landing in the same cycle
  always_comb begin
    state_nxt = state;
    clr_step  = 1'b0;
    en_flip   = 3'b000;
    bump      = 1'b0;
    unique case (state)
      MANUAL: begin
        if (deb_sw) begin
          state_nxt = AUTO;
          clr_step  = 1'b1;
        end else begin
          en_flip = press[2:0];
          bump    = press[3];
        end
      end
      AUTO: begin
        if (!deb_sw)       state_nxt = MANUAL;
        else if (press[3]) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (!deb_sw)       state_nxt = MANUAL;
        else if (press[3]) state_nxt = AUTO;
      end
      default: state_nxt = MANUAL;
    endcase
  end

  assign colour = (state == MANUAL) ? en : step;
  assign pwm_on = (pwm_cnt <= bright);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      bright  <= '1;
      step    <= '0;
      timer   <= '0;
      pwm_cnt <= '0;
    end else begin
      en      <= en ^ en_flip;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (bump) bright <= bright + 1'b1;
      if (clr_step) begin
        step  <= '0;
        timer <= '0;
      end else if (state == AUTO) begin
        if (timer == STEP_LAST) begin
          timer <= '0;
          step  <= step + 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
      led_w <= 1'b0;
    end else begin
      led_r <= colour[0] & pwm_on;
      led_g <= colour[1] & pwm_on;
      led_b <= colour[2] & pwm_on;
      led_w <= (colour == 3'b111) & pwm_on;
    end
  end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: directed table plus randomized
// stimulus against a cycle-level behavioural model.
module tb_rgb_led_sequencer;

  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam int PB   = 2;
  localparam int MAXB = (1 << PB) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic [3:0] btn;
  logic       led_r, led_b, led_g, led_w;

  int vectors = 0;
  int errors  = 0;

  rgb_led_sequencer #(
    .DEB_CYCLES(DEB),
    .STEP_CYCLES(STEP),
    .PWM_BITS(PB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn(btn),
    .led_r(led_r),
    .led_b(led_b),
    .led_g(led_g),
    .led_w(led_w)
  );

  always #5 clk = ~clk;

  // behavioural model; mode 0 manual, 1 auto, 2 pause
  logic [4:0] m_s1, m_s2, m_deb, m_debp;
  int         m_cnt [5];
  int         m_mode, m_bright, m_timer, m_pwm;
  logic [2:0] m_en, m_step;
  logic [3:0] m_led;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_mode = 0; m_bright = MAXB; m_timer = 0; m_pwm = 0;
    m_en = '0; m_step = '0; m_led = '0;
  endfunction

  function automatic void model_step(logic [4:0] r);
    logic [2:0] col;
    logic [3:0] pr;
    logic       dsw;
    col   = (m_mode == 0) ? m_en : m_step;
    m_led = (m_pwm <= m_bright) ? {col == 3'b111, col} : 4'h0;
    pr    = m_deb[3:0] & ~m_debp[3:0];
    dsw   = m_deb[4];
    if (m_mode == 0) begin
      if (dsw) begin
        m_mode = 1; m_step = 0; m_timer = 0;
      end else begin
        m_en = m_en ^ pr[2:0];
        if (pr[3]) m_bright = (m_bright + 1) % (MAXB + 1);
      end
    end else begin
      if (m_mode == 1) begin
        m_timer = m_timer + 1;
        if (m_timer == STEP) begin
          m_timer = 0;
          m_step  = 3'((int'(m_step) + 1) % 8);
        end
      end
      if (!dsw)       m_mode = 0;
      else if (pr[3]) m_mode = (m_mode == 1) ? 2 : 1;
    end
    m_debp = m_deb;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_cnt[i] = 0;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    m_s2  = m_s1;
    m_s1  = r;
    m_pwm = (m_pwm + 1) % (MAXB + 1);
  endfunction

  function automatic logic [3:0] leds();
    return {led_w, led_b, led_g, led_r};
  endfunction

  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {w,b,g,r}=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step({sw, btn});
    @(negedge clk);
    check("model", leds(), rst_n ? m_led : 4'h0);
  endtask

  typedef struct {
    logic       rst;
    logic       s;
    logic [3:0] b;
    int         cyc;
    logic       chk;
    logic [3:0] exp;
    int         cnt;
  } row_t;

  localparam int NROWS   = 34;
  localparam int RST_ROW = 31;
  row_t tbl [NROWS];

  initial begin
    int hi [4];
    logic [3:0] l;
    tbl = '{
      '{0, 0, 4'hF,  3, 1, 4'b0000, -1},
      '{1, 0, 4'hF,  1, 1, 4'b0000, -1},
      '{1, 0, 4'h0, 12, 1, 4'b0000, -1},
      '{1, 0, 4'h1,  3, 0, 4'b0000, -1},
      '{1, 0, 4'h0, 10, 1, 4'b0000, -1},
      '{1, 0, 4'h1, 10, 1, 4'b0001, -1},
      '{1, 0, 4'h0, 10, 1, 4'b0001, -1},
      '{1, 0, 4'h2, 10, 1, 4'b0011, -1},
      '{1, 0, 4'h0, 10, 1, 4'b0011, -1},
      '{1, 0, 4'h4, 10, 1, 4'b1111, -1},
      '{1, 0, 4'h0, 10, 1, 4'b1111, -1},
      '{1, 0, 4'h8, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h0, 16, 0, 4'b0000,  4},
      '{1, 0, 4'h8, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h0, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h8, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h0, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h8, 10, 0, 4'b0000, -1},
      '{1, 0, 4'h0, 10, 1, 4'b1111, -1},
      '{1, 1, 4'h0,  8, 1, 4'b0000, -1},
      '{1, 1, 4'h0,  8, 1, 4'b0001, -1},
      '{1, 1, 4'h0, 16, 1, 4'b0011, -1},
      '{1, 1, 4'h0, 32, 1, 4'b1111, -1},
      '{1, 1, 4'h0,  8, 1, 4'b0000, -1},
      '{1, 1, 4'h0, 10, 1, 4'b0001, -1},
      '{1, 1, 4'h8, 10, 1, 4'b0010, -1},
      '{1, 1, 4'h0, 40, 1, 4'b0010, -1},
      '{1, 1, 4'h8, 10, 1, 4'b0010, -1},
      '{1, 1, 4'h0,  4, 1, 4'b0011, -1},
      '{1, 0, 4'h0, 10, 1, 4'b1111, -1},
      '{1, 1, 4'h0, 20, 1, 4'b0001, -1},
      '{0, 0, 4'h0,  3, 1, 4'b0000, -1},
      '{1, 0, 4'h0, 12, 1, 4'b0000, -1},
      '{1, 0, 4'h1, 10, 1, 4'b0001, -1}
    };

    rst_n = 1'b0;
    sw    = 1'b0;
    btn   = 4'h0;
    model_reset();

    for (int k = 0; k < NROWS; k++) begin
      if (k == RST_ROW) begin
        // drop reset mid low phase: LEDs must clear before any edge
        #1 rst_n = 1'b0;
        #1 check("async_rst", leds(), 4'h0);
      end
      rst_n = tbl[k].rst;
      sw    = tbl[k].s;
      btn   = tbl[k].b;
      for (int j = 0; j < 4; j++) hi[j] = 0;
      for (int c = 0; c < tbl[k].cyc; c++) begin
        tick();
        l = leds();
        for (int j = 0; j < 4; j++) hi[j] += int'(l[j]);
      end
      if (tbl[k].chk)
        check($sformatf("row%0d", k), leds(), tbl[k].exp);
      if (tbl[k].cnt >= 0)
        for (int j = 0; j < 4; j++)
          check_int($sformatf("row%0d_duty%0d", k, j), hi[j], tbl[k].cnt);
    end

    for (int s = 0; s < 300; s++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) btn = 4'h0;
      for (int c = 0; c < int'($urandom_range(1, 10)); c++) tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
